uart_rx_cfg: RTL and testbench

Parametrised successor UART receiver that converts the asynchronous serial line into parallel words for the command/console path.
Generalises the fixed 8N1 receiver with the following additions:
- configurable data width, parity and stop bits
- ready/valid output holding register with overrun detection
- framing, parity and break error reporting
Sits between the board RX pin and the command decoder or FIFO.

---
 rtl/uart_rx_cfg.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a ready/valid holding register and error flags.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_s_q, rx_s_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   stopz_q, stopz_d;
    logic                   done_q, done_d;
    logic                   frm_perr_q, frm_perr_d;
    logic                   frm_ferr_q, frm_ferr_d;
    logic                   frm_brk_q, frm_brk_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;
    logic                   bit_val;

`ifdef UART_RX_MAJORITY_EN
    // Two older copies of rx_s let the vote finish on the same clock as a single sample would.
    logic rx_h1_q, rx_h2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    assign bit_val = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
    assign bit_val = rx_s_q;
`endif

    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        stopz_d    = stopz_q;
        done_d     = 1'b0;
        frm_perr_d = frm_perr_q;
        frm_ferr_d = frm_ferr_q;
        frm_brk_d  = frm_brk_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        state_d    = S_DATA;
                        bit_idx_d  = '0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                        stopz_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Bits shift in at the MSB so the first bit on the line ends up at bit 0.
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PAR: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    par_bit_d  = bit_val;
                    perr_acc_d = (PARITY == 1) ? ~((^shift_q) ^ bit_val) : ((^shift_q) ^ bit_val);
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // The frame completes on the last stop sample so a following start edge is not missed.
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    ferr_acc_d = ferr_acc_q | ~bit_val;
                    stopz_d    = stopz_q & ~bit_val;
                    if (stop_idx_q == STOP_LAST) begin
                        done_d     = 1'b1;
                        frm_perr_d = perr_acc_q;
                        frm_ferr_d = ferr_acc_q | ~bit_val;
                        frm_brk_d  = (shift_q == '0) && ((PARITY == 0) || !par_bit_q)
                                     && stopz_q && !bit_val;
                        state_d    = bit_val ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: a completed frame loads only if the slot is empty or being drained.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = 1'b0;
        ovr_d   = ovr_q;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (done_q) begin
            brk_d = frm_brk_q;
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = frm_perr_q;
                ferr_d  = frm_ferr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            stopz_q    <= 1'b0;
            done_q     <= 1'b0;
            frm_perr_q <= 1'b0;
            frm_ferr_q <= 1'b0;
            frm_brk_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            stopz_q    <= stopz_d;
            done_q     <= done_d;
            frm_perr_q <= frm_perr_d;
            frm_ferr_q <= frm_ferr_d;
            frm_brk_q  <= frm_brk_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of uart_rx_cfg in an 8N1 and a 7E2 configuration.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetN;
    logic       rxA, readyA, rxB, readyB;
    logic [7:0] dataA;
    logic [6:0] dataB;
    logic       validA, perrA, ferrA, brkA, ovrA, busyA;
    logic       validB, perrB, ferrB, brkB, ovrB, busyB;

    int checks   = 0;
    int failures = 0;
    int latency;
    int pulseCount;
    int validSeen;
    logic [7:0] capData;
    logic       capPerr, capFerr, capBrk, capValidNext;

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
        .clk(clk), .reset_n(resetN), .rx(rxA), .data(dataA), .valid(validA), .ready(readyA),
        .parity_err(perrA), .frame_err(ferrA), .break_det(brkA), .overrun(ovrA), .busy(busyA)
    );

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dutB (
        .clk(clk), .reset_n(resetN), .rx(rxB), .data(dataB), .valid(validB), .ready(readyB),
        .parity_err(perrB), .frame_err(ferrB), .break_det(brkB), .overrun(ovrB), .busy(busyB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveLine(input int sel, input logic v);
        if (sel == 0) rxA = v;
        else          rxB = v;
    endtask

    // frame is LSB-first including the start bit; each bit is held CPB clocks.
    task automatic applyStimulus(input int sel, input logic [15:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            driveLine(sel, frame[i]);
            repeat (CPB) @(posedge clk);
            #1;
        end
        driveLine(sel, 1'b1);
    endtask

    function automatic logic [15:0] frame8n1(input logic [7:0] d, input logic stopBit);
        return {6'b0, stopBit, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame7e2(input logic [6:0] d, input logic p);
        return {5'b0, 2'b11, p, d, 1'b0};
    endfunction

    task automatic consumeA();
        readyA = 1'b1;
        tick();
        readyA = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetN = 1'b0;
        rxA = 1'b1; rxB = 1'b1;
        readyA = 1'b0; readyB = 1'b0;
        #12;
        checkOutput("rst_validA", validA, 0);
        checkOutput("rst_dataA", dataA, 0);
        checkOutput("rst_busyA", busyA, 0);
        checkOutput("rst_flagsA", {perrA, ferrA, brkA, ovrA}, 0);
        checkOutput("rst_validB", validB, 0);
        checkOutput("rst_dataB", dataB, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        repeat (4) tick();

        // 1: 8N1 0xA5 with ready high, latency and single-clock valid
        readyA = 1'b1;
        latency = 0;
        fork
            applyStimulus(0, frame8n1(8'hA5, 1'b1), 10);
            begin
                for (int k = 1; k <= 200; k++) begin
                    tick();
                    if (validA) begin
                        latency = k;
                        break;
                    end
                end
                capData = dataA; capPerr = perrA; capFerr = ferrA; capBrk = brkA;
                tick();
                capValidNext = validA;
            end
        join
        readyA = 1'b0;
        checkOutput("t1_latency_window", (latency >= 150 && latency <= 165), 1);
        checkOutput("t1_data", capData, 8'hA5);
        checkOutput("t1_errs", {capPerr, capFerr, capBrk}, 0);
        checkOutput("t1_valid_one_clk", capValidNext, 0);

        // 2: 7E2 parity good then bad
        applyStimulus(1, frame7e2(7'h41, 1'b0), 11);
        checkOutput("t2a_valid", validB, 1);
        checkOutput("t2a_data", dataB, 7'h41);
        checkOutput("t2a_perr", perrB, 0);
        checkOutput("t2a_ferr", ferrB, 0);
        readyB = 1'b1; tick(); readyB = 1'b0;
        checkOutput("t2_consumed", validB, 0);
        applyStimulus(1, frame7e2(7'h41, 1'b1), 11);
        checkOutput("t2b_valid", validB, 1);
        checkOutput("t2b_data", dataB, 7'h41);
        checkOutput("t2b_perr", perrB, 1);
        readyB = 1'b1; tick(); readyB = 1'b0;

        // 3: stop bit low, then a held break
        applyStimulus(0, frame8n1(8'h3C, 1'b0), 10);
        checkOutput("t3_valid", validA, 1);
        checkOutput("t3_data", dataA, 8'h3C);
        checkOutput("t3_ferr", ferrA, 1);
        checkOutput("t3_perr", perrA, 0);
        consumeA();
        checkOutput("t3_consumed", validA, 0);
        repeat (CPB) tick();
        pulseCount = 0;
        fork
            begin
                driveLine(0, 1'b0);
                repeat (20 * CPB) @(posedge clk);
                #1;
                driveLine(0, 1'b1);
            end
            begin
                for (int k = 0; k < 20 * CPB; k++) begin
                    tick();
                    if (brkA) pulseCount++;
                end
            end
        join
        checkOutput("t3_break_pulses", pulseCount, 1);
        checkOutput("t3_busy_held_low", busyA, 1);
        checkOutput("t3_brk_data", dataA, 0);
        checkOutput("t3_brk_ferr", ferrA, 1);
        repeat (2 * CPB) tick();
        checkOutput("t3_idle_after", busyA, 0);
        checkOutput("t3_no_extra_frame", ovrA, 0);
        consumeA();

        // 4: overrun with ready low
        applyStimulus(0, frame8n1(8'h11, 1'b1), 10);
        checkOutput("t4_first_data", dataA, 8'h11);
        checkOutput("t4_ovr_before", ovrA, 0);
        applyStimulus(0, frame8n1(8'h22, 1'b1), 10);
        checkOutput("t4_data_kept", dataA, 8'h11);
        checkOutput("t4_ovr", ovrA, 1);
        checkOutput("t4_valid_held", validA, 1);
        consumeA();
        checkOutput("t4_valid_drop", validA, 0);
        checkOutput("t4_ovr_sticky", ovrA, 1);

        // 5: short start glitch
        driveLine(0, 1'b0);
        repeat (CPB / 4) @(posedge clk);
        #1;
        driveLine(0, 1'b1);
        checkOutput("t5_busy_start", busyA, 1);
        validSeen = 0;
        for (int k = 0; k < 3 * CPB; k++) begin
            tick();
            if (validA) validSeen++;
        end
        checkOutput("t5_no_valid", validSeen, 0);
        checkOutput("t5_idle", busyA, 0);

`ifdef UART_RX_MAJORITY_EN
        // single-clock low inside data bit 3 of 0xFF
        for (int i = 0; i < 10; i++) begin
            driveLine(0, (i == 0) ? 1'b0 : 1'b1);
            if (i == 4) begin
                repeat (9) @(posedge clk);
                #1;
                driveLine(0, 1'b0);
                @(posedge clk);
                #1;
                driveLine(0, 1'b1);
                repeat (CPB - 10) @(posedge clk);
            end else begin
                repeat (CPB) @(posedge clk);
            end
            #1;
        end
        checkOutput("t5_maj_data", dataA, 8'hFF);
        checkOutput("t5_maj_valid", validA, 1);
        consumeA();
`endif

        // 6: reset mid-frame, then a clean frame
        applyStimulus(0, frame8n1(8'h77, 1'b1), 10);
        checkOutput("t6_pre_valid", validA, 1);
        begin
            logic [15:0] fr;
            fr = frame8n1(8'h5A, 1'b1);
            for (int i = 0; i < 4; i++) begin
                driveLine(0, fr[i]);
                repeat (CPB) @(posedge clk);
                #1;
            end
            driveLine(0, fr[4]);
            repeat (CPB / 2) @(posedge clk);
            #1;
        end
        checkOutput("t6_busy_mid", busyA, 1);
        resetN = 1'b0;
        #2;
        checkOutput("t6_rst_valid", validA, 0);
        checkOutput("t6_rst_data", dataA, 0);
        checkOutput("t6_rst_ovr", ovrA, 0);
        checkOutput("t6_rst_busy", busyA, 0);
        checkOutput("t6_rst_flags", {perrA, ferrA, brkA}, 0);
        driveLine(0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (CPB) tick();
        applyStimulus(0, frame8n1(8'h5A, 1'b1), 10);
        checkOutput("t6_after_valid", validA, 1);
        checkOutput("t6_after_data", dataA, 8'h5A);
        checkOutput("t6_after_errs", {perrA, ferrA, ovrA}, 0);
        consumeA();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
